// File: rtl/cpu_defs_pkg.sv
// Shared control definitions for the 16-bit multi-cycle CPU.
// Latency: n/a (constants, types and one helper only).
// Backpressure: n/a.
//
// Holds the opcode map, ALUOp codes consumed by ALU Control, FSM state
// encodings, datapath mux select constants and the packed strobe bundle
// produced by the main control FSM.
package cpu_defs;

  // Opcode map (IR[15:12])
  localparam logic [3:0] OP_R0   = 4'b0000;
  localparam logic [3:0] OP_R1   = 4'b0001;
  localparam logic [3:0] OP_R2   = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUBI = 4'b1010;
  localparam logic [3:0] OP_SLTI = 4'b1011;

  // ALUOp codes, shared with ALU Control
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_TWO    = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // FSM states; encodings are visible on the State debug port
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  // Datapath strobe bundle
  typedef struct packed {
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  // True for an opcode that has a defined instruction behind it
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_R0, OP_R1, OP_R2, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_SUBI, OP_SLTI: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class.sv
// Opcode classifier: splits IR[15:12] into instruction-class flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output tracks opcode continuously.
//
// Ports: opcode in (4); is_r/is_i/is_lw/is_sw/is_beq/is_bne/is_illegal out (1 each).
module opcode_class
  import cpu_defs::*;
(
  input  logic [3:0] opcode,
  output logic       is_r,
  output logic       is_i,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_bne,
  output logic       is_illegal
);

  always_comb begin
    is_r   = (opcode == OP_R0) || (opcode == OP_R1) || (opcode == OP_R2);
    is_i   = (opcode == OP_ADDI) || (opcode == OP_SUBI) || (opcode == OP_SLTI);
    is_lw  = (opcode == OP_LW);
    is_sw  = (opcode == OP_SW);
    is_beq = (opcode == OP_BEQ);
    is_bne = (opcode == OP_BNE);
    is_illegal = !op_legal(opcode);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences IF/ID/EX/MEM/WB and drives datapath strobes.
// Latency: branch 3, R/I/SW 4, LW 5 cycles; IF and MEM add one cycle per MemReady=0.
// Backpressure: MemReady=0 holds IF or MEM with strobes held; TRAP holds until Reset.
//
// Ports: Clock, Reset (async, active-high); opcode[3:0], Zero, MemReady in;
// datapath strobes (PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, ALUSrcA,
// ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite) out; IllegalOp (sticky),
// State[2:0] and RetireCount[RET_W-1:0] (wrapping) out.
module multicycle_control
  import cpu_defs::*;
#(
  parameter int RET_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             IllegalOp,
  output logic [2:0]       State,
  output logic [RET_W-1:0] RetireCount
);

  state_t state;
  ctrl_t  ctrl;
  logic   retire;
  logic   is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_illegal;

  opcode_class u_class (
    .opcode     (opcode),
    .is_r       (is_r),
    .is_i       (is_i),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_bne     (is_bne),
    .is_illegal (is_illegal)
  );

  // Last cycle of an instruction whose advance condition holds this cycle
  always_comb begin
    retire = 1'b0;
    case (state)
      S_WB:    retire = 1'b1;
      S_MEM:   retire = is_sw && MemReady;
      S_EX:    retire = is_beq || is_bne;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= S_IF;
      IllegalOp   <= 1'b0;
      RetireCount <= '0;
    end else begin
      if (retire)
        RetireCount <= RetireCount + RET_W'(1);
      case (state)
        S_IF:
          if (MemReady)
            state <= S_ID;
        S_ID:
          if (is_illegal) begin
            state     <= S_TRAP;
            IllegalOp <= 1'b1;
          end else begin
            state <= S_EX;
          end
        S_EX:
          if (is_lw || is_sw)
            state <= S_MEM;
          else if (is_beq || is_bne)
            state <= S_IF;
          else
            state <= S_WB;
        S_MEM:
          if (MemReady)
            state <= is_lw ? S_WB : S_IF;
        S_WB:
          state <= S_IF;
        S_TRAP:
          state <= S_TRAP;
        default:
          state <= S_IF;
      endcase
    end
  end

  // Moore strobe decode; only the IF fetch handshake and the branch decision
  // look at inputs other than state/opcode.
  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALUOP_ADD;
    case (state)
      S_IF: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = ALUB_TWO;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = MemReady;
        ctrl.pcwrite = MemReady;
      end
      S_ID: begin
        // Speculative branch target into ALUOut while the opcode is decoded
        ctrl.alusrcb = ALUB_IMM_SH;
      end
      S_EX: begin
        ctrl.alusrca = 1'b1;
        if (is_r) begin
          ctrl.alusrcb = ALUB_RT;
          ctrl.aluop   = ALUOP_R;
        end else if (is_i) begin
          ctrl.alusrcb = ALUB_IMM;
          ctrl.aluop   = ALUOP_I;
        end else if (is_lw || is_sw) begin
          ctrl.alusrcb = ALUB_IMM;
        end else if (is_beq || is_bne) begin
          ctrl.alusrcb = ALUB_RT;
          ctrl.aluop   = ALUOP_SUB;
          ctrl.pcsrc   = PCSRC_ALUOUT;
          ctrl.pcwrite = (is_beq && Zero) || (is_bne && !Zero);
        end
      end
      S_MEM: begin
        ctrl.iord     = 1'b1;
        ctrl.memread  = is_lw;
        ctrl.memwrite = is_sw;
      end
      S_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = is_r;
        ctrl.memtoreg = is_lw;
      end
      default: ;
    endcase
  end

  assign State    = state;
  assign PCWrite  = ctrl.pcwrite;
  assign PCSrc    = ctrl.pcsrc;
  assign IorD     = ctrl.iord;
  assign IRWrite  = ctrl.irwrite;
  assign MemRead  = ctrl.memread;
  assign MemWrite = ctrl.memwrite;
  assign ALUSrcA  = ctrl.alusrca;
  assign ALUSrcB  = ctrl.alusrcb;
  assign ALUOp    = ctrl.aluop;
  assign RegDst   = ctrl.regdst;
  assign MemtoReg = ctrl.memtoreg;
  assign RegWrite = ctrl.regwrite;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, built with a 4-bit retire counter.
// Latency: checks per-cycle state sequences against hand-derived values.
// Backpressure: exercises MemReady stalls in IF-adjacent and MEM states.
module tb_multicycle_control;

  localparam int RW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [3:0]    opcode;
  logic          Zero;
  logic          MemReady;
  logic          PCWrite;
  logic [1:0]    PCSrc;
  logic          IorD;
  logic          IRWrite;
  logic          MemRead;
  logic          MemWrite;
  logic          ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic [1:0]    ALUOp;
  logic          RegDst;
  logic          MemtoReg;
  logic          RegWrite;
  logic          IllegalOp;
  logic [2:0]    State;
  logic [RW-1:0] RetireCount;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_ret;

  multicycle_control #(.RET_W(RW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .opcode      (opcode),
    .Zero        (Zero),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCSrc       (PCSrc),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .IllegalOp   (IllegalOp),
    .State       (State),
    .RetireCount (RetireCount)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Plain instruction driver with no checks, used to set up state
  task automatic run_add();
    opcode = 4'b0001;
    repeat (4) step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; MemReady = 1'b1; opcode = 4'b0000; Zero = 1'b0;
    #3;
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", State); end
    checks++; if (RetireCount !== 4'd0) begin errors++; $display("FAIL reset_retire: got %0d want 0", RetireCount); end
    checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", IllegalOp); end
    checks++; if (IRWrite !== 1'b1 || MemRead !== 1'b1) begin errors++; $display("FAIL reset_if_decode: IRWrite=%b MemRead=%b want 1 1", IRWrite, MemRead); end
    step();
    Reset = 1'b0;
    run_add();
    checks++; if (RetireCount !== 4'd1) begin errors++; $display("FAIL pre_reset_retire: got %0d want 1", RetireCount); end
    // LW into MEM, stall there, then hit Reset asynchronously
    opcode = 4'b0100;
    step(); step(); step();
    MemReady = 1'b0;
    step();
    checks++; if (State !== 3'd3 || MemRead !== 1'b1) begin errors++; $display("FAIL lw_mem_stall: State=%0d MemRead=%b want 3 1", State, MemRead); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (State !== 3'd0 || RetireCount !== 4'd0 || IllegalOp !== 1'b0) begin
      errors++; $display("FAIL midmem_reset: State=%0d Ret=%0d Ill=%b want 0 0 0", State, RetireCount, IllegalOp);
    end
    checks++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0 || MemRead !== 1'b1) begin
      errors++; $display("FAIL reset_stall_decode: IRWrite=%b PCWrite=%b MemRead=%b want 0 0 1", IRWrite, PCWrite, MemRead);
    end
    MemReady = 1'b1;
    step();
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_hold: State=%0d want 0", State); end
    Reset = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_add();
    // Garbage on opcode while fetching must not matter
    opcode = 4'b1111; MemReady = 1'b1;
    checks++; if (State !== 3'd0 || ALUSrcB !== 2'b01 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL add_if: State=%0d ALUSrcB=%b PCWrite=%b want 0 01 1", State, ALUSrcB, PCWrite);
    end
    step();
    opcode = 4'b0001;
    checks++; if (State !== 3'd1 || ALUSrcB !== 2'b11 || ALUOp !== 2'b00) begin
      errors++; $display("FAIL add_id: State=%0d ALUSrcB=%b ALUOp=%b want 1 11 00", State, ALUSrcB, ALUOp);
    end
    step();
    checks++; if (State !== 3'd2 || ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
      errors++; $display("FAIL add_ex: State=%0d ALUOp=%b A=%b B=%b want 2 10 1 00", State, ALUOp, ALUSrcA, ALUSrcB);
    end
    step();
    checks++; if (State !== 3'd4 || RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
      errors++; $display("FAIL add_wb: State=%0d RegWrite=%b RegDst=%b MemtoReg=%b want 4 1 1 0", State, RegWrite, RegDst, MemtoReg);
    end
    step();
    exp_ret = exp_ret + 4'd1;
    checks++; if (State !== 3'd0 || RetireCount !== exp_ret) begin
      errors++; $display("FAIL add_retire: State=%0d Ret=%0d want 0 %0d", State, RetireCount, exp_ret);
    end
  endtask

  task automatic test_lw_stall();
    int cyc;
    opcode = 4'b0100; MemReady = 1'b1; cyc = 0;
    step(); cyc++;
    step(); cyc++;
    checks++; if (State !== 3'd2 || ALUSrcB !== 2'b10 || ALUOp !== 2'b00) begin
      errors++; $display("FAIL lw_ex: State=%0d ALUSrcB=%b ALUOp=%b want 2 10 00", State, ALUSrcB, ALUOp);
    end
    step(); cyc++;
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReady = 1'b1;
      checks++; if (State !== 3'd3 || MemRead !== 1'b1 || IorD !== 1'b1 || MemWrite !== 1'b0 || RetireCount !== exp_ret) begin
        errors++; $display("FAIL lw_mem_hold%0d: State=%0d MemRead=%b IorD=%b MemWrite=%b Ret=%0d want 3 1 1 0 %0d",
                           i, State, MemRead, IorD, MemWrite, RetireCount, exp_ret);
      end
      step(); cyc++;
    end
    checks++; if (State !== 3'd4 || MemtoReg !== 1'b1 || RegDst !== 1'b0 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL lw_wb: State=%0d MemtoReg=%b RegDst=%b RegWrite=%b want 4 1 0 1", State, MemtoReg, RegDst, RegWrite);
    end
    step(); cyc++;
    exp_ret = exp_ret + 4'd1;
    checks++; if (State !== 3'd0 || cyc !== 8 || RetireCount !== exp_ret) begin
      errors++; $display("FAIL lw_total: State=%0d cycles=%0d Ret=%0d want 0 8 %0d", State, cyc, RetireCount, exp_ret);
    end
  endtask

  task automatic test_sw();
    opcode = 4'b0101; MemReady = 1'b1;
    step(); step(); step();
    checks++; if (State !== 3'd3 || MemWrite !== 1'b1 || MemRead !== 1'b0 || IorD !== 1'b1) begin
      errors++; $display("FAIL sw_mem: State=%0d MemWrite=%b MemRead=%b IorD=%b want 3 1 0 1", State, MemWrite, MemRead, IorD);
    end
    step();
    exp_ret = exp_ret + 4'd1;
    checks++; if (State !== 3'd0 || RetireCount !== exp_ret) begin
      errors++; $display("FAIL sw_retire: State=%0d Ret=%0d want 0 %0d", State, RetireCount, exp_ret);
    end
  endtask

  task automatic test_branch();
    logic [3:0] ops [4];
    logic       zs  [4];
    logic       pcw [4];
    ops = '{4'b0110, 4'b0111, 4'b0110, 4'b0111};
    zs  = '{1'b1,    1'b1,    1'b0,    1'b0};
    pcw = '{1'b1,    1'b0,    1'b0,    1'b1};
    MemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k]; Zero = zs[k];
      step(); step();
      checks++; if (State !== 3'd2 || PCWrite !== pcw[k] || PCSrc !== 2'b01 || ALUOp !== 2'b01) begin
        errors++; $display("FAIL branch_ex%0d: op=%b Z=%b State=%0d PCWrite=%b PCSrc=%b ALUOp=%b want 2 %b 01 01",
                           k, ops[k], zs[k], State, PCWrite, PCSrc, ALUOp, pcw[k]);
      end
      step();
      exp_ret = exp_ret + 4'd1;
      checks++; if (State !== 3'd0 || RetireCount !== exp_ret) begin
        errors++; $display("FAIL branch_retire%0d: State=%0d Ret=%0d want 0 %0d", k, State, RetireCount, exp_ret);
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_addi();
    opcode = 4'b1001; MemReady = 1'b1;
    step(); step();
    checks++; if (ALUOp !== 2'b11 || ALUSrcB !== 2'b10 || ALUSrcA !== 1'b1) begin
      errors++; $display("FAIL addi_ex: ALUOp=%b ALUSrcB=%b ALUSrcA=%b want 11 10 1", ALUOp, ALUSrcB, ALUSrcA);
    end
    step();
    checks++; if (State !== 3'd4 || RegDst !== 1'b0 || MemtoReg !== 1'b0 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL addi_wb: State=%0d RegDst=%b MemtoReg=%b RegWrite=%b want 4 0 0 1", State, RegDst, MemtoReg, RegWrite);
    end
    step();
    exp_ret = exp_ret + 4'd1;
  endtask

  task automatic test_illegal();
    logic [14:0] strobes;
    opcode = 4'b1111; MemReady = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      strobes = {PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite};
      checks++; if (State !== 3'd7 || IllegalOp !== 1'b1 || strobes !== 15'd0 || RetireCount !== exp_ret) begin
        errors++; $display("FAIL trap%0d: State=%0d Ill=%b strobes=%h Ret=%0d want 7 1 0000 %0d",
                           i, State, IllegalOp, strobes, RetireCount, exp_ret);
      end
      MemReady = ~MemReady;
      opcode = 4'b0001;
      step();
    end
    MemReady = 1'b1;
    do_reset();
    checks++; if (State !== 3'd0 || IllegalOp !== 1'b0 || RetireCount !== 4'd0) begin
      errors++; $display("FAIL trap_reset: State=%0d Ill=%b Ret=%0d want 0 0 0", State, IllegalOp, RetireCount);
    end
  endtask

  task automatic test_wrap();
    MemReady = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      run_add();
      if (n == 15) begin
        checks++; if (RetireCount !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d want 15", RetireCount); end
      end
    end
    checks++; if (RetireCount !== 4'd0 || State !== 3'd0) begin
      errors++; $display("FAIL wrap: Ret=%0d State=%0d want 0 0", RetireCount, State);
    end
  endtask

  initial begin
    exp_ret = '0;
    test_reset();
    test_add();
    test_lw_stall();
    test_sw();
    test_branch();
    test_addi();
    test_illegal();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
